// File: rtl/thread_seq.sv
// Round-robin instruction sequencer for a four-requester thread processor.
// Steps each granted instruction through register reads, ALU execute and write-back.
module thread_seq #(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_instr,
  output logic [3:0]  req_ready,
  output logic        done,
  output logic [1:0]  done_tid,
  output logic        busy,
  output logic [1:0]  read_id,
  output logic        en_a,
  output logic        en_b,
  output logic [1:0]  alu_op,
  output logic        en_alu_out,
  output logic        en_write,
  output logic [1:0]  write_id
);

  localparam int unsigned CNT_W   = 2;
  localparam int unsigned INSTR_W = 8;
  localparam int unsigned NREQ    = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RDA  = 3'd1,
    RDB  = 3'd2,
    LDB  = 3'd3,
    EXE  = 3'd4,
    WAIT = 3'd5,
    WB   = 3'd6
  } state_t;

  state_t             state, state_n;
  logic [1:0]         ptr_q;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [INSTR_W-1:0] instr_q;
  logic [1:0]         tid_q;

  logic               grant;
  logic               grant_found;
  logic [1:0]         grant_idx;
  logic [1:0]         cand;

  logic [1:0] op_q, rd_q, rs1_q, rs2_q;
  assign op_q  = instr_q[7:6];
  assign rd_q  = instr_q[5:4];
  assign rs1_q = instr_q[3:2];
  assign rs2_q = instr_q[1:0];

  // Round-robin search starting one past the last granted requester
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = 2'd0;
    cand        = 2'd0;
    for (int i = 1; i <= int'(NREQ); i++) begin
      cand = 2'(ptr_q + 2'(i));
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign grant = (state == IDLE) && grant_found && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr_q   <= 2'd3;
      cnt_q   <= '0;
      instr_q <= '0;
      tid_q   <= 2'd0;
    end else begin
      state <= state_n;
      cnt_q <= cnt_n;
      if (grant) begin
        ptr_q   <= grant_idx;
        tid_q   <= grant_idx;
        instr_q <= req_instr[INSTR_W*grant_idx +: INSTR_W];
      end
    end
  end

  // Next state and Moore-decoded control lines
  always_comb begin
    state_n    = state;
    cnt_n      = cnt_q;
    req_ready  = 4'b0000;
    done       = 1'b0;
    done_tid   = 2'd0;
    busy       = (state != IDLE);
    read_id    = 2'd0;
    en_a       = 1'b0;
    en_b       = 1'b0;
    alu_op     = 2'd0;
    en_alu_out = 1'b0;
    en_write   = 1'b0;
    write_id   = 2'd0;

    unique case (state)
      IDLE: begin
        if (grant) begin
          req_ready = 4'(1) << grant_idx;
          state_n   = RDA;
        end
      end
      RDA: begin
        read_id = rs1_q;
        state_n = RDB;
      end
      RDB: begin
        read_id = rs2_q;
        en_a    = 1'b1;
        state_n = LDB;
      end
      LDB: begin
        read_id = rs2_q;
        en_b    = 1'b1;
        state_n = EXE;
      end
      EXE: begin
        alu_op     = op_q;
        en_alu_out = 1'b1;
        if (ALU_LAT == 1) begin
          state_n = WB;
        end else begin
          cnt_n   = CNT_W'(ALU_LAT - 1);
          state_n = WAIT;
        end
      end
      WAIT: begin
        alu_op = op_q;
        if (cnt_q == CNT_W'(1)) begin
          state_n = WB;
        end else begin
          cnt_n = cnt_q - CNT_W'(1);
        end
      end
      WB: begin
        en_write = 1'b1;
        write_id = rd_q;
        done     = 1'b1;
        done_tid = tid_q;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_thread_seq.sv
// Bench for thread_seq: directed vectors, corner sequences and random traffic
// checked against a per-instruction timeline model, on ALU_LAT=1 and ALU_LAT=3 instances.
module tb_thread_seq;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_instr;

  logic [3:0] a_req_ready, b_req_ready;
  logic       a_done, b_done, a_busy, b_busy;
  logic [1:0] a_done_tid, b_done_tid, a_read_id, b_read_id;
  logic       a_en_a, b_en_a, a_en_b, b_en_b;
  logic [1:0] a_alu_op, b_alu_op;
  logic       a_en_alu_out, b_en_alu_out, a_en_write, b_en_write;
  logic [1:0] a_write_id, b_write_id;

  int errors = 0;
  int checks = 0;

  thread_seq #(.ALU_LAT(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_instr(req_instr),
    .req_ready(a_req_ready), .done(a_done), .done_tid(a_done_tid), .busy(a_busy),
    .read_id(a_read_id), .en_a(a_en_a), .en_b(a_en_b), .alu_op(a_alu_op),
    .en_alu_out(a_en_alu_out), .en_write(a_en_write), .write_id(a_write_id)
  );

  thread_seq #(.ALU_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_instr(req_instr),
    .req_ready(b_req_ready), .done(b_done), .done_tid(b_done_tid), .busy(b_busy),
    .read_id(b_read_id), .en_a(b_en_a), .en_b(b_en_b), .alu_op(b_alu_op),
    .en_alu_out(b_en_alu_out), .en_write(b_en_write), .write_id(b_write_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {req_ready, busy, read_id, en_a, en_b, alu_op, en_alu_out, en_write, write_id, done, done_tid}
  function automatic logic [17:0] pk(logic [3:0] rr, logic bz, logic [1:0] rid, logic ea,
                                     logic eb, logic [1:0] aop, logic eao, logic ew,
                                     logic [1:0] wid, logic dn, logic [1:0] dtid);
    return {rr, bz, rid, ea, eb, aop, eao, ew, wid, dn, dtid};
  endfunction

  function automatic logic [17:0] act_a();
    return pk(a_req_ready, a_busy, a_read_id, a_en_a, a_en_b, a_alu_op, a_en_alu_out,
              a_en_write, a_write_id, a_done, a_done_tid);
  endfunction

  function automatic logic [17:0] act_b();
    return pk(b_req_ready, b_busy, b_read_id, b_en_a, b_en_b, b_alu_op, b_en_alu_out,
              b_en_write, b_write_id, b_done, b_done_tid);
  endfunction

  task automatic chk(string name, logic [17:0] act, logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%05h required=%05h", name, $time, act, exp);
    end
  endtask

  // Model: each instruction is a timeline of phases 1..4+lat after its grant
  bit         m_act [2];
  int         m_ph  [2];
  int         m_ptr [2];
  int         m_tid [2];
  logic [7:0] m_ins [2];

  function automatic int lat_of(int m);
    return (m == 0) ? 1 : 3;
  endfunction

  function automatic int pick(int p, logic [3:0] v);
    for (int k = 1; k <= 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [17:0] mexp(int m, logic r, logic [3:0] v);
    int lat = lat_of(m);
    int p = m_ph[m];
    logic [1:0] op  = m_ins[m][7:6];
    logic [1:0] rd  = m_ins[m][5:4];
    logic [1:0] rs1 = m_ins[m][3:2];
    logic [1:0] rs2 = m_ins[m][1:0];
    logic [3:0] rr = 4'b0000;
    if (!m_act[m]) begin
      if (!r && v != 4'b0000) rr = 4'b0001 << pick(m_ptr[m], v);
      return pk(rr, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    if (p == 1) return pk(0, 1, rs1, 0, 0, 0, 0, 0, 0, 0, 0);
    if (p == 2) return pk(0, 1, rs2, 1, 0, 0, 0, 0, 0, 0, 0);
    if (p == 3) return pk(0, 1, rs2, 0, 1, 0, 0, 0, 0, 0, 0);
    if (p == 4) return pk(0, 1, 0, 0, 0, op, 1, 0, 0, 0, 0);
    if (p < 4 + lat) return pk(0, 1, 0, 0, 0, op, 0, 0, 0, 0, 0);
    return pk(0, 1, 0, 0, 0, 0, 0, 1, rd, 1, 2'(m_tid[m]));
  endfunction

  task automatic mupd(int m, logic r, logic [3:0] v, logic [31:0] ia);
    int j;
    if (r) begin
      m_act[m] = 0;
      m_ptr[m] = 3;
    end else if (!m_act[m]) begin
      if (v != 4'b0000) begin
        j = pick(m_ptr[m], v);
        m_act[m] = 1;
        m_ph[m]  = 1;
        m_ptr[m] = j;
        m_tid[m] = j;
        m_ins[m] = ia[8*j +: 8];
      end
    end else if (m_ph[m] == 4 + lat_of(m)) begin
      m_act[m] = 0;
    end else begin
      m_ph[m]++;
    end
  endtask

  // Compare both instances with the model away from the clock edge
  task automatic sample();
    @(negedge clk);
    chk("model_lat1", act_a(), mexp(0, rst, req_valid));
    chk("model_lat3", act_b(), mexp(1, rst, req_valid));
  endtask

  task automatic advance();
    @(posedge clk);
    mupd(0, rst, req_valid, req_instr);
    mupd(1, rst, req_valid, req_instr);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [31:0] instr;
    logic [17:0] exp;
  } vec_t;

  vec_t vt [8];
  int   n;
  bit   seen;

  initial begin
    vt[0] = '{1'b1, 4'b0000, 32'h0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    vt[1] = '{1'b0, 4'b0001, 32'h61, pk(4'b0001, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    vt[2] = '{1'b0, 4'b0000, 32'h0, pk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    vt[3] = '{1'b0, 4'b0000, 32'h0, pk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0)};
    vt[4] = '{1'b0, 4'b0000, 32'h0, pk(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0)};
    vt[5] = '{1'b0, 4'b0000, 32'h0, pk(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0)};
    vt[6] = '{1'b0, 4'b0000, 32'h0, pk(0, 1, 0, 0, 0, 0, 0, 1, 2, 1, 0)};
    vt[7] = '{1'b0, 4'b0000, 32'h0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};

    for (int m = 0; m < 2; m++) begin
      m_act[m] = 0; m_ph[m] = 0; m_ptr[m] = 3; m_tid[m] = 0; m_ins[m] = 8'h00;
    end
    rst = 1'b1; req_valid = 4'b0000; req_instr = 32'h0;
    advance();
    advance();

    // Directed single instruction on the ALU_LAT=1 instance
    for (int i = 0; i < 8; i++) begin
      rst = vt[i].rst; req_valid = vt[i].valid; req_instr = vt[i].instr;
      sample();
      chk($sformatf("vec%0d", i), act_a(), vt[i].exp);
      advance();
    end

    // Wrap-around: pointer at 1 with only requester 0 valid
    rst = 1'b1; req_valid = 4'b0000;
    sample(); advance();
    rst = 1'b0; req_valid = 4'b0010; req_instr = 32'h0000_9B00;
    sample();
    chk("grant_r1", {a_req_ready, 14'h0}, {4'b0010, 14'h0});
    advance();
    req_valid = 4'b0000;
    for (int i = 0; i < 5; i++) begin sample(); advance(); end
    req_valid = 4'b0001; req_instr = 32'h0000_00E4;
    sample();
    chk("wrap_r0", {a_req_ready, 14'h0}, {4'b0001, 14'h0});
    advance();
    req_valid = 4'b0000;
    for (int i = 0; i < 5; i++) begin sample(); advance(); end
    req_valid = 4'b0011;
    sample();
    chk("ptr_now_0", {a_req_ready, 14'h0}, {4'b0010, 14'h0});
    advance();

    // Reset while in LDB abandons the instruction
    req_valid = 4'b0000;
    sample(); advance();
    sample(); advance();
    rst = 1'b1;
    sample(); advance();
    rst = 1'b0; req_valid = 4'b1100;
    sample();
    chk("rst_ldb_quiet", {a_busy, a_en_write, a_done}, 3'b000);
    chk("rst_ldb_regrant", {a_req_ready, 14'h0}, {4'b0100, 14'h0});
    advance();
    req_valid = 4'b0000;
    for (int i = 0; i < 8; i++) begin sample(); advance(); end

    // ALU_LAT=3 latency: grant to WB spans 8 cycles
    rst = 1'b1; sample(); advance();
    rst = 1'b0; req_valid = 4'b0001; req_instr = 32'h0000_00D6;
    sample(); advance();
    req_valid = 4'b0000;
    seen = 0; n = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      sample();
      if (b_done) begin seen = 1; n = i; end
      advance();
    end
    chk("lat3_wb_cycle", 18'(n), 18'd7);

    // Random traffic including mid-instruction resets and toggling requests
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      req_valid = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      req_instr = $urandom;
      sample();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
